// File: rtl/uart_mem_master.sv
// CPU-side bridge: one word read/write becomes a UART request frame; the UART reply is decoded.
// Accepts one request at a time (req_ready only in IDLE); resp_valid pulses once per accepted request.
module uart_mem_master #(
  parameter int CLKS_PER_BIT = 4,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        Tx,
  input  logic        Rx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_t;

  state_t          state_q, state_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic            we_q, we_d;
  logic [71:0]     frame_q, frame_d;
  logic [3:0]      tx_byte_q, tx_byte_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic            tx_q, tx_d;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [2:0]      rx_bytes_q, rx_bytes_d;
  logic [31:0]     acc_q, acc_d;
  logic            started_q, started_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [3:0]      tx_nbytes;
  logic [7:0]      tx_cur;

  assign tx_nbytes  = we_q ? 4'd9 : 4'd5;
  assign tx_cur     = frame_q[7:0];
  assign Tx         = tx_q;
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    rx_state_d = rx_state_q;
    we_d       = we_q;
    frame_d    = frame_q;
    tx_byte_d  = tx_byte_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_d       = tx_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_bytes_d = rx_bytes_q;
    acc_d      = acc_q;
    started_d  = started_q;
    to_cnt_d   = to_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        rx_state_d = R_HUNT;
        if (req_valid) begin
          state_d    = S_SEND;
          we_d       = req_we;
          frame_d    = {req_wdata, req_addr, (req_we ? 8'h57 : 8'h52)};
          tx_byte_d  = '0;
          tx_bit_d   = '0;
          tx_cnt_d   = '0;
          rx_bytes_d = '0;
          acc_d      = '0;
          started_d  = 1'b0;
          to_cnt_d   = '0;
        end
      end
      S_SEND: begin
        rx_state_d = R_HUNT;
        if (tx_byte_q == tx_nbytes) begin
          state_d = S_WAIT;
          tx_d    = 1'b1;
        end else begin
          // Bit slot 0 is start, 1..8 data LSB first, 9 is stop.
          if (tx_bit_q == 4'd0)      tx_d = 1'b0;
          else if (tx_bit_q == 4'd9) tx_d = 1'b1;
          else                       tx_d = tx_cur[tx_bit_q[2:0] - 3'd1];
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
              tx_bit_d  = '0;
              tx_byte_d = tx_byte_q + 4'd1;
              frame_d   = {8'h00, frame_q[71:8]};
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
          end
        end
      end
      S_WAIT: begin
        case (rx_state_q)
          R_HUNT: begin
            if (rx_prev_q && !rx_s2_q) begin
              rx_state_d = R_START;
              rx_cnt_d   = '0;
            end
          end
          R_START: begin
            if (rx_cnt_q == BIT_HALF) begin
              rx_cnt_d = '0;
              if (!rx_s2_q) begin
                rx_state_d = R_DATA;
                rx_bit_d   = '0;
                started_d  = 1'b1;
              end else begin
                rx_state_d = R_HUNT;
              end
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end
          R_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
              rx_cnt_d = '0;
              rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
              rx_bit_d = rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end
          default: begin
            if (rx_cnt_q == BIT_LAST) begin
              rx_cnt_d   = '0;
              rx_state_d = R_HUNT;
              if (!rx_s2_q) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                rdata_d = '0;
              end else begin
                acc_d      = {rx_sh_q, acc_q[31:8]};
                rx_bytes_d = rx_bytes_q + 3'd1;
                if (rx_bytes_q == (we_q ? 3'd0 : 3'd3)) begin
                  state_d = S_DONE;
                  err_d   = we_q ? (rx_sh_q != 8'h06) : 1'b0;
                  rdata_d = we_q ? 32'h0 : {rx_sh_q, acc_q[31:8]};
                end
              end
            end else begin
              rx_cnt_d = rx_cnt_q + CW'(1);
            end
          end
        endcase
        // The timeout only guards the wait for the first confirmed start bit.
        if (!started_q) begin
          if (to_cnt_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        rx_state_d = R_HUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_state_q <= R_HUNT;
      we_q       <= 1'b0;
      frame_q    <= '0;
      tx_byte_q  <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_bytes_q <= '0;
      acc_q      <= '0;
      started_q  <= 1'b0;
      to_cnt_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_state_q <= rx_state_d;
      we_q       <= we_d;
      frame_q    <= frame_d;
      tx_byte_q  <= tx_byte_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_q       <= tx_d;
      rx_s1_q    <= Rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_bytes_q <= rx_bytes_d;
      acc_q      <= acc_d;
      started_q  <= started_d;
      to_cnt_q   <= to_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_uart_mem_master.sv
// Directed bench for uart_mem_master: decodes the Tx frames, plays the responder on Rx.
module tb_uart_mem_master;
  localparam int CPB = 4;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        Rx = 1'b1;
  logic        req_ready, resp_valid, resp_err, busy, Tx;
  logic [31:0] resp_rdata;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          resp_cnt = 0;
  int          last_cyc = 0;
  int          acc_cnt = 0;
  int          acc_seen_cyc = 0;
  int          accept_cyc = 0;
  int          tx_start_cyc = 0;
  int          tx_first_cyc = 0;
  int          p = 0;
  int          a = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        last_busy = 1'b0;
  logic [7:0]  b;

  uart_mem_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .Tx(Tx), .Rx(Rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      last_cyc   = cyc;
      last_rdata = resp_rdata;
      last_err   = resp_err;
      last_busy  = busy;
    end
    if (req_valid && req_ready) begin
      acc_cnt++;
      acc_seen_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) tick();
    tick();
    accept_cyc = cyc;
    req_valid  = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready_lo", 32'(req_ready), 32'd0);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    v = '0;
    for (int i = 0; i < 500 && Tx !== 1'b0; i++) tick();
    tx_start_cyc = cyc;
    tick(); tick();
    check("tx_start", 32'(Tx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) tick();
      v[k] = Tx;
    end
    repeat (CPB) tick();
    check("tx_stop", 32'(Tx), 32'd1);
  endtask

  task automatic expect_frame(input logic [71:0] f, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      recv_byte(v);
      if (i == 0) tx_first_cyc = tx_start_cyc;
      check("tx_byte", 32'(v), 32'(f[8*i +: 8]));
    end
  endtask

  task automatic send_rx(input logic [7:0] v, input logic stopv);
    Rx = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      Rx = v[k];
      repeat (CPB) tick();
    end
    Rx = stopv;
    repeat (CPB) tick();
    Rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_rx(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_resp(input int prev);
    for (int i = 0; i < 1000 && resp_cnt == prev; i++) tick();
    repeat (3) tick();
    check("resp_pulse", 32'(resp_cnt), 32'(prev + 1));
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // Read 0x1004, reply DEADBEEF
    p = resp_cnt;
    issue(1'b0, 32'h0000_1004, 32'h0);
    expect_frame({32'h0, 32'h0000_1004, 8'h52}, 5);
    check("rd_first_start", 32'(tx_first_cyc), 32'(accept_cyc + 1));
    repeat (5) tick();
    send_word(32'hDEAD_BEEF);
    wait_resp(p);
    check("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    check("rd_err", 32'(last_err), 32'd0);
    check("rd_busy_at_resp", 32'(last_busy), 32'd1);
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_idle_ready", 32'(req_ready), 32'd1);

    // Timeout: no reply
    p = resp_cnt;
    issue(1'b0, 32'h0000_0020, 32'h0);
    expect_frame({32'h0, 32'h0000_0020, 8'h52}, 5);
    wait_resp(p);
    check("to_latency", 32'(last_cyc - accept_cyc), 32'(201 + TO));
    check("to_err", 32'(last_err), 32'd1);
    check("to_rdata", last_rdata, 32'h0);

    // Write with OK ack, then with bad ack
    p = resp_cnt;
    issue(1'b1, 32'h0000_0010, 32'h1122_3344);
    expect_frame({32'h1122_3344, 32'h0000_0010, 8'h57}, 9);
    repeat (5) tick();
    send_rx(8'h06, 1'b1);
    wait_resp(p);
    check("wr_ok_err", 32'(last_err), 32'd0);
    check("wr_ok_rdata", last_rdata, 32'h0);
    p = resp_cnt;
    issue(1'b1, 32'h0000_0010, 32'h1122_3344);
    expect_frame({32'h1122_3344, 32'h0000_0010, 8'h57}, 9);
    repeat (5) tick();
    send_rx(8'h15, 1'b1);
    wait_resp(p);
    check("wr_nak_err", 32'(last_err), 32'd1);
    check("wr_nak_rdata", last_rdata, 32'h0);

    // One-cycle glitch in WAIT, then a good reply
    p = resp_cnt;
    issue(1'b0, 32'h0000_0030, 32'h0);
    expect_frame({32'h0, 32'h0000_0030, 8'h52}, 5);
    repeat (5) tick();
    Rx = 1'b0;
    tick();
    Rx = 1'b1;
    repeat (20) tick();
    check("glitch_quiet", 32'(resp_cnt), 32'(p));
    send_word(32'h1234_5678);
    wait_resp(p);
    check("glitch_rdata", last_rdata, 32'h1234_5678);
    check("glitch_err", 32'(last_err), 32'd0);

    // Framing error on second reply byte
    p = resp_cnt;
    issue(1'b0, 32'h0000_0040, 32'h0);
    expect_frame({32'h0, 32'h0000_0040, 8'h52}, 5);
    repeat (5) tick();
    send_rx(8'hA5, 1'b1);
    send_rx(8'h5A, 1'b0);
    wait_resp(p);
    check("frm_err", 32'(last_err), 32'd1);
    check("frm_rdata", last_rdata, 32'h0);

    // Reset during the third request byte
    p = resp_cnt;
    issue(1'b0, 32'h0000_0050, 32'h0);
    recv_byte(b);
    recv_byte(b);
    repeat (4) tick();
    check("mid_tx_low", 32'(Tx), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_tx", 32'(Tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    repeat (60) tick();
    check("mid_rst_no_resp", 32'(resp_cnt), 32'(p));
    issue(1'b0, 32'h0000_0060, 32'h0);
    expect_frame({32'h0, 32'h0000_0060, 8'h52}, 5);
    repeat (5) tick();
    send_word(32'hCAFE_F00D);
    wait_resp(p);
    check("post_rst_rdata", last_rdata, 32'hCAFE_F00D);
    check("post_rst_err", 32'(last_err), 32'd0);

    // Back-to-back with req_valid held high
    p = resp_cnt;
    a = acc_cnt;
    req_we = 1'b0; req_addr = 32'h0000_0070; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == a; i++) tick();
    req_addr = 32'h0000_0074;
    expect_frame({32'h0, 32'h0000_0070, 8'h52}, 5);
    repeat (5) tick();
    send_word(32'h0102_0304);
    a = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt == a; i++) tick();
    req_valid = 1'b0;
    check("b2b_resp_cnt", 32'(resp_cnt), 32'(p + 1));
    check("b2b_rdata1", last_rdata, 32'h0102_0304);
    check("b2b_accept_cycle", 32'(acc_seen_cyc), 32'(last_cyc + 1));
    expect_frame({32'h0, 32'h0000_0074, 8'h52}, 5);
    repeat (5) tick();
    send_word(32'h0A0B_0C0D);
    wait_resp(p + 1);
    check("b2b_rdata2", last_rdata, 32'h0A0B_0C0D);

    // Stray byte while idle
    p = resp_cnt;
    send_rx(8'h55, 1'b1);
    repeat (50) tick();
    check("idle_noise_resp", 32'(resp_cnt), 32'(p));
    check("idle_noise_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_mem_master.md
Name: uart_mem_master

Overview:
- CPU-side bridge that turns single-word memory requests into UART request frames on Tx and decodes the UART response frames arriving on Rx.
- It is the initiator matching the UART memory responder (ram_uart) already on the board/bench.
- Sits between the core's load/store port and the serial link; one outstanding request at a time.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit (>=4); 4 for simulation, board value set at instantiation
TIMEOUT_CYC, 4096, cycles to wait for a response start bit after the last request stop bit

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  word address
req_wdata  input  32  write data
resp_valid  output  1  one-cycle pulse, response complete
resp_rdata  output  32  read data; valid with resp_valid
resp_err  output  1  error flag; valid with resp_valid
busy  output  1  high from accept until the resp_valid cycle inclusive
Tx  output  1  UART serial out, idle high
Rx  input  1  UART serial in, idle high

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; Tx=1; req_ready=1 once rst is low; resp_valid=0, resp_rdata=0, resp_err=0, busy=0; all counters cleared. Reset mid-frame aborts immediately; Tx returns high on the next edge with no partial stop bit.
- UART format: 8N1, LSB first. Each bit is held exactly CLKS_PER_BIT cycles. Stop bit is 1 bit. There is no inter-byte gap.
- Request frame:
  - Command byte first: 0x52 for a read, 0x57 for a write.
  - Then req_addr as 4 bytes, LSB first.
  - For a write, then req_wdata as 4 bytes, LSB first.
  - Read frame is 5 bytes; write frame is 9 bytes.
- Response frame:
  - Read: 4 data bytes, LSB first, assembled into resp_rdata.
  - Write: 1 ack byte; 0x06 means OK.
- States:
  - IDLE: req_ready=1. When req_valid=1, capture we/addr/wdata and go to SEND; the request inputs are ignored after the capture edge.
  - SEND: shift the frame out. Go to WAIT when the last stop bit completes.
  - WAIT: the Rx engine collects the expected byte count; the timeout counter runs only until the first start bit is detected. Go to DONE on the last byte, a framing error, or timeout.
  - DONE: one cycle with resp_valid=1, then IDLE.
- First Tx start bit is driven on the edge after the accept edge.
- Rx engine:
  - Two-flop synchronizer on Rx.
  - Start is detected on a synchronized falling edge and re-checked low at mid-bit (CLKS_PER_BIT/2); a high sample there is a glitch, ignored, and the engine returns to hunting.
  - Data bits are sampled at mid-bit.
  - Stop bit sampled low = framing error: resp_err=1, resp_rdata=0.
- Timeout: TIMEOUT_CYC elapses in WAIT with no start bit → resp_err=1, resp_rdata=0.
- Write ack other than 0x06 → resp_err=1. resp_rdata is 0 for all writes.
- Rx activity while in IDLE or SEND is discarded and never produces resp_valid.
- resp_rdata and resp_err hold their values until the next DONE.
- A new request may be accepted on the cycle after DONE.

Test Plan:
- Read, CLKS_PER_BIT=4, addr=0x00001004: Tx carries bytes 52 04 10 00 00, frame is 200 cycles. Bench returns EF BE AD DE → resp_valid pulse, resp_rdata=0xDEADBEEF, resp_err=0; req_ready low from the cycle after accept until back in IDLE.
- Write, addr=0x10, wdata=0x11223344: Tx carries 57 10 00 00 00 44 33 22 11 (360 cycles). Bench replies 06 → resp_err=0, resp_rdata=0. Repeat with reply 15 → resp_err=1.
- Timeout: read request with no reply → resp_valid exactly TIMEOUT_CYC cycles after the last stop bit ends, resp_err=1, resp_rdata=0.
- Framing and glitch:
  - Reply whose second byte has stop bit=0 → resp_err=1.
  - A 1-cycle low glitch on Rx in WAIT is ignored; a following correct reply gives resp_err=0.
- Reset mid-SEND: assert rst during the third request byte → next edge Tx=1, busy=0, no resp_valid. A following read completes normally.
- Back-to-back and idle noise: req_valid held high → second request accepted the cycle after the first DONE. A stray byte on Rx while IDLE produces no resp_valid.
